// File: rtl/alu_exec_stage_pkg.sv
// Shared ALU control codes and helpers for the execute stage.
// Codes 4'hE and 4'hF are unassigned and yield a zero result.
package alu_exec_stage_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int TAG_W_DEFAULT = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_LT   = 4'd3,
        ALU_LTU  = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_EQ   = 4'd10,
        ALU_GTE  = 4'd11,
        ALU_GTEU = 4'd12,
        ALU_NOP  = 4'd13
    } alu_ctrl_e;

    // BNE and friends reuse the compare bit with an optional inversion.
    function automatic logic branch_taken(input logic is_branch,
                                          input logic invert,
                                          input logic cmp_bit);
        return is_branch & (cmp_bit ^ invert);
    endfunction

endpackage

// File: rtl/alu_exec_stage_alu.sv
// Purely combinational ALU: control code plus two operands in, result out.
module alu_exec_stage_alu
    import alu_exec_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [3:0]      ctrl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt_s;
    logic       lt_s;
    logic       ltu_s;
    logic       eq_s;

    assign shamt_s = b[4:0];
    assign lt_s    = $signed(a) < $signed(b);
    assign ltu_s   = a < b;
    assign eq_s    = a == b;

    // Result select; compares produce a single LSB so bit 0 feeds branch logic.
    always_comb begin
        result = {XLEN{1'b0}};
        case (ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt_s;
            ALU_SRL:  result = a >> shamt_s;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt_s);
            ALU_LT:   result = {{(XLEN-1){1'b0}}, lt_s};
            ALU_LTU:  result = {{(XLEN-1){1'b0}}, ltu_s};
            ALU_GTE:  result = {{(XLEN-1){1'b0}}, ~lt_s};
            ALU_GTEU: result = {{(XLEN-1){1'b0}}, ~ltu_s};
            ALU_EQ:   result = {{(XLEN-1){1'b0}}, eq_s};
            ALU_XOR:  result = a ^ b;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_NOP:  result = b;
            default:  result = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: ALU plus branch decision held in a one-entry output register
// with valid/ready handshake, backpressure and flush.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = TAG_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_alu_ctrl,
    input  logic [XLEN-1:0]  in_op_a,
    input  logic [XLEN-1:0]  in_op_b,
    input  logic             in_is_branch,
    input  logic             in_br_invert,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_br_taken,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  alu_result_s;
    logic             accept_s;
    logic             br_taken_s;

    logic             out_valid_d,    out_valid_q;
    logic [XLEN-1:0]  out_result_d,   out_result_q;
    logic             out_br_taken_d, out_br_taken_q;
    logic [TAG_W-1:0] out_tag_d,      out_tag_q;

    alu_exec_stage_alu #(.XLEN(XLEN)) u_alu (
        .ctrl   (in_alu_ctrl),
        .a      (in_op_a),
        .b      (in_op_b),
        .result (alu_result_s)
    );

    assign in_ready   = !out_valid_q || out_ready;
    assign accept_s   = in_valid && in_ready;
    assign br_taken_s = branch_taken(in_is_branch, in_br_invert, alu_result_s[0]);

    // Next-state for the output slot; flush beats accept, accept beats drain.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_result_d   = out_result_q;
        out_br_taken_d = out_br_taken_q;
        out_tag_d      = out_tag_q;
        if (accept_s) begin
            out_result_d   = alu_result_s;
            out_br_taken_d = br_taken_s;
            out_tag_d      = in_tag;
        end else begin
            out_result_d   = out_result_q;
            out_br_taken_d = out_br_taken_q;
            out_tag_d      = out_tag_q;
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output slot registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_result_q   <= {XLEN{1'b0}};
            out_br_taken_q <= 1'b0;
            out_tag_q      <= {TAG_W{1'b0}};
        end else begin
            out_valid_q    <= out_valid_d;
            out_result_q   <= out_result_d;
            out_br_taken_q <= out_br_taken_d;
            out_tag_q      <= out_tag_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_br_taken = out_br_taken_q;
    assign out_tag      = out_tag_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: expected results are queued on accept
// and compared on delivery; direct checks cover reset, stall and flush.
module tb_alu_exec_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_alu_ctrl;
    logic [31:0] in_op_a;
    logic [31:0] in_op_b;
    logic        in_is_branch;
    logic        in_br_invert;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_br_taken;
    logic [4:0]  out_tag;

    typedef struct {
        logic [31:0] result;
        logic        br;
        logic [4:0]  tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    alu_exec_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_alu_ctrl  (in_alu_ctrl),
        .in_op_a      (in_op_a),
        .in_op_b      (in_op_b),
        .in_is_branch (in_is_branch),
        .in_br_invert (in_br_invert),
        .in_tag       (in_tag),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_br_taken (out_br_taken),
        .out_tag      (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Delivery monitor: compare each delivered result against the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check_eq("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("sb_result", out_result, e.result);
                check_eq("sb_br", {31'd0, out_br_taken}, {31'd0, e.br});
                check_eq("sb_tag", {27'd0, out_tag}, {27'd0, e.tag});
            end
        end
    end

    task automatic send(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input logic isbr, input logic inv, input logic [4:0] tag,
                        input logic [31:0] exp_res, input logic exp_br);
        exp_t e;
        int   waited;
        in_valid     = 1'b1;
        in_alu_ctrl  = ctrl;
        in_op_a      = a;
        in_op_b      = b;
        in_is_branch = isbr;
        in_br_invert = inv;
        in_tag       = tag;
        waited       = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
        end else begin
            e.result = exp_res;
            e.br     = exp_br;
            e.tag    = tag;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("latency_valid", {31'd0, out_valid}, 32'd1);
        check_eq("latency_result", out_result, exp_res);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b1;
        in_alu_ctrl  = 4'd0;
        in_op_a      = 32'd1;
        in_op_b      = 32'd2;
        in_is_branch = 1'b0;
        in_br_invert = 1'b0;
        in_tag       = 5'd0;
        flush        = 1'b0;
        out_ready    = 1'b1;

        // Reset held two cycles with an op offered.
        idle(2);
        @(negedge clk);
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_result", out_result, 32'd0);
        check_eq("rst_br", {31'd0, out_br_taken}, 32'd0);
        check_eq("rst_tag", {27'd0, out_tag}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Back-to-back with out_ready high.
        send(4'd0, 32'd5, 32'd7, 1'b0, 1'b0, 5'd1, 32'd12, 1'b0);
        send(4'd1, 32'd3, 32'd5, 1'b0, 1'b0, 5'd2, 32'hFFFF_FFFE, 1'b0);
        send(4'd7, 32'h8000_0000, 32'd4, 1'b0, 1'b0, 5'd3, 32'hF800_0000, 1'b0);
        send(4'd6, 32'h8000_0000, 32'd4, 1'b0, 1'b0, 5'd4, 32'h0800_0000, 1'b0);
        send(4'd5, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 1'b0, 5'd5, 32'h0000_0FF0, 1'b0);
        send(4'd8, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 1'b0, 5'd6, 32'h0000_FFF0, 1'b0);
        send(4'd9, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 1'b0, 5'd7, 32'h0000_F000, 1'b0);
        send(4'd3, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 5'd8, 32'd1, 1'b0);
        send(4'd12, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 5'd9, 32'd1, 1'b0);
        idle(1);

        // Backpressure: LTU result held for three stalled cycles.
        out_ready = 1'b0;
        send(4'd4, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd10, 32'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
            check_eq("stall_result", out_result, 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;

        // Branches; the first is accepted on the same edge the LTU result leaves.
        send(4'd10, 32'd9, 32'd9, 1'b1, 1'b0, 5'd11, 32'd1, 1'b1);
        send(4'd10, 32'd9, 32'd9, 1'b1, 1'b1, 5'd12, 32'd1, 1'b0);
        send(4'd11, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 5'd13, 32'd0, 1'b0);
        send(4'd0, 32'd1, 32'd0, 1'b0, 1'b0, 5'd14, 32'd1, 1'b0);

        // Edge codes.
        send(4'd2, 32'd3, 32'd33, 1'b0, 1'b0, 5'd15, 32'd6, 1'b0);
        send(4'd13, 32'h0000_FFFF, 32'h1234_5000, 1'b0, 1'b0, 5'd16, 32'h1234_5000, 1'b0);
        send(4'hF, 32'd5, 32'd7, 1'b0, 1'b0, 5'd17, 32'd0, 1'b0);
        idle(1);

        // Flush of a stalled op while another op is offered.
        out_ready = 1'b0;
        send(4'd0, 32'd2, 32'd2, 1'b0, 1'b0, 5'd18, 32'd4, 1'b0);
        flush        = 1'b1;
        in_valid     = 1'b1;
        in_alu_ctrl  = 4'd9;
        in_op_a      = 32'hFFFF_FFFF;
        in_op_b      = 32'h0000_00FF;
        in_tag       = 5'd19;
        @(negedge clk);
        check_eq("flush_in_ready", {31'd0, in_ready}, 32'd0);
        if (sb_q.size() > 0) void'(sb_q.pop_back());
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        idle(3);

        // Flush wins over an accept when the slot is empty.
        flush    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_prio_valid", {31'd0, out_valid}, 32'd0);
        idle(3);

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
